mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencer for the EX-stage iterative multiplier: accepts one MUL/MULH/MULHSU/MULHU
//  request, runs radix-2 shift-add over WIDTH cycles on one internal ripple-carry adder,
//  fixes the sign and returns one 32-bit result.
//  Sits between EX issue logic and writeback. EX stalls on req_ready/resp_valid.
// PARAMETERS
//  WIDTH  32  operand/result width; equals `DATA_BUS_WIDTH; must be >= 2
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      pipeline kill; aborts any in-flight op
//  req_valid    in   1      request present
//  req_ready    out  1      block can accept (comb: state==IDLE && !flush)
//  req_op       in   2      00 MUL, 01 MULH (s*s), 10 MULHSU (op1 s, op2 u), 11 MULHU (u*u)
//  req_op1      in   WIDTH  multiplicand (rs1)
//  req_op2      in   WIDTH  multiplier (rs2)
//  resp_valid   out  1      result valid, held until resp_ready
//  resp_ready   in   1      consumer takes result
//  resp_result  out  WIDTH  MUL: product[W-1:0]; others: product[2W-1:W]
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Clock/reset: one clock domain; reset is asynchronous and active-low.
//  Reset: state=IDLE, count=0, acc=0, resp_valid=0, resp_result=0, busy=0.
//   Reset mid-operation discards the op. No response is issued.
//  FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE: accept on req_valid && req_ready. Latch op, |op1|, |op2| as unsigned W-bit
//   magnitudes, and neg = sign(op1 if signed) ^ sign(op2 if signed).
//   Load acc_hi=0 and acc_lo=|op2|. Clear count. Go to CALC.
//  CALC, one iteration per cycle:
//   If acc_lo[0], {c,s} = acc_hi + |op1| on the rca; otherwise {c,s} = {0,acc_hi}.
//   Then {acc_hi,acc_lo} <= {c,s,acc_lo[W-1:1]}.
//   count++; leave to FIX after the cycle where count==WIDTH-1.
//  FIX, one cycle: if neg, {acc_hi,acc_lo} <= ~{acc_hi,acc_lo}+1 (2W-bit); else hold.
//   Then capture resp_result per req_op and go to DONE.
//  DONE: resp_valid=1, resp_result stable. On resp_ready, go to IDLE.
//   resp_valid drops the cycle after the handshake.
//   No new request is accepted while in DONE; back-to-back ops need one IDLE cycle.
//  Latency: fixed, independent of data/sign.
//   With the accept edge at cycle t, resp_valid is first high at cycle t+WIDTH+2.
//  Width rules: |-2^(W-1)| = 2^(W-1) fits the unsigned magnitude. No overflow is possible.
//   The 2W-bit product is exact. MUL low half is identical for all sign modes.
//  Flush: any state -> IDLE next edge. acc is don't-care, resp_valid=0.
//   Flush beats resp_ready and beats req_valid; the request is not accepted that cycle.
//  req_* is sampled only at accept and may change afterwards.
//  resp_ready while !resp_valid is ignored.
//  Zero operand needs no special case; it still takes full latency.
// TESTING
//  T1 MULHU 0xFFFFFFFF*0xFFFFFFFF -> resp_result=0xFFFFFFFE at cycle t+34.
//     Repeat with MUL -> 0x00000001.
//  T2 MULH 0x80000000*0x80000000 -> 0x40000000.
//     MULH 0xFFFFFFFF(-1)*0x00000007 -> 0xFFFFFFFF; MUL same -> 0xFFFFFFF9.
//  T3 MULHSU 0xFFFFFFFF(-1)*0xFFFFFFFF(u) -> 0xFFFFFFFF.
//     MUL 0*0x12345678 -> 0 with identical latency.
//  T4 Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result stable.
//     req_ready=0 throughout; drop occurs 1 cycle after resp_ready=1.
//  T5 flush at CALC count=5, with a simultaneous new req_valid -> IDLE next edge.
//     No resp_valid; the next request accepted returns a correct result.
//  T6 Deassert rst_n asynchronously mid-CALC -> outputs reset immediately.
//     After release, MUL 3*5 -> 15 at t+34.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between EX issue logic and the iterative multiplier.
//   req_valid/req_ready  : request handshake, op code and both operands
//   resp_valid/resp_ready: response handshake and the 32-bit result
// master = EX issue / writeback side, slave = multiplier sequencer.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_op1;
    logic [WIDTH-1:0] req_op2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;

    modport master (
        output req_valid,
        output req_op,
        output req_op1,
        output req_op2,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_result
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_op1,
        input  req_op2,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_result
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative MUL/MULH/MULHSU/MULHU sequencer for the EX stage.
// Operands are converted to unsigned magnitudes, multiplied radix-2 shift-add
// over WIDTH cycles on a single ripple-carry adder, then the 2W-bit product is
// negated if the true result is negative and the requested half is returned.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   flush  in   pipeline kill, aborts any in-flight op (beats all handshakes)
//   bus    slave modport of mul_seq_ctrl_if (request/response handshakes)
//   busy   out  sequencer is not idle
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high unless flushing
// CALC  | one shift-add iteration per cycle, WIDTH cycles total
// FIX   | apply sign to the 2W-bit product, capture the selected half
// DONE  | resp_valid high, result held until resp_ready
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mul_seq_ctrl_if.slave  bus,
    output logic           busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mag1_q,   mag1_d;
    logic             neg_q,    neg_d;
    logic [1:0]       op_q,     op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             op1_signed;
    logic             op2_signed;
    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;

    logic [WIDTH-1:0]   rca_addend;
    logic [WIDTH-1:0]   rca_sum;
    logic               rca_cout;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    // Handshake outputs
    assign bus.req_ready   = (state_q == S_IDLE) && !flush;
    assign bus.resp_valid  = (state_q == S_DONE);
    assign bus.resp_result = result_q;
    assign busy            = (state_q != S_IDLE);

    assign accept = bus.req_valid && bus.req_ready;

    // Operand signedness: MULH treats both as signed, MULHSU only rs1.
    // MUL is run unsigned since the low half does not depend on sign mode.
    assign op1_signed = (bus.req_op == 2'b01) || (bus.req_op == 2'b10);
    assign op2_signed = (bus.req_op == 2'b01);
    assign op1_neg    = op1_signed && bus.req_op1[WIDTH-1];
    assign op2_neg    = op2_signed && bus.req_op2[WIDTH-1];

    // The most negative value maps to 2^(W-1), which still fits unsigned.
    assign op1_mag = op1_neg ? (~bus.req_op1 + ONE_W) : bus.req_op1;
    assign op2_mag = op2_neg ? (~bus.req_op2 + ONE_W) : bus.req_op2;

    // Single ripple-carry adder shared by every CALC iteration.
    always_comb begin : rca
        logic carry;
        rca_addend = acc_lo_q[0] ? mag1_q : '0;
        rca_sum    = '0;
        carry      = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            rca_sum[i] = acc_hi_q[i] ^ rca_addend[i] ^ carry;
            carry      = (acc_hi_q[i] & rca_addend[i]) |
                         (carry & (acc_hi_q[i] ^ rca_addend[i]));
        end
        rca_cout = carry;
    end

    assign prod_raw = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod_raw + ONE_2W) : prod_raw;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag1_d   = mag1_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = bus.req_op;
                    mag1_d   = op1_mag;
                    neg_d    = op1_neg ^ op2_neg;
                    acc_hi_d = '0;
                    acc_lo_d = op2_mag;
                    count_d  = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // Multiplier bits are consumed from acc_lo's LSB while the
                // partial product shifts in from the top.
                {acc_hi_d, acc_lo_d} = {rca_cout, rca_sum, acc_lo_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                {acc_hi_d, acc_lo_d} = prod_fix;
                result_d = (op_q == 2'b00) ? prod_fix[WIDTH-1:0]
                                           : prod_fix[2*WIDTH-1:WIDTH];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Kill wins over every handshake, including the response.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag1_q   <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag1_q   <= mag1_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    mul_seq_ctrl_if #(.WIDTH(W)) bus ();

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference product: sign/zero extend to 64 bits, multiply, pick a half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        b64 = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = a64 * b64;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Transaction-level model: an op is outstanding from accept until the
    // response handshake; its result appears W+2 cycles after accept.
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_exp  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_exp  <= ref_mul(bus.req_op, bus.req_op1, bus.req_op2);
            end
        end else if (m_age >= W + 2 && bus.resp_ready) begin
            m_busy <= 1'b0;
        end else if (m_age < W + 2) begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_busy);
            check("req_ready", bus.req_ready, !m_busy && !flush);
            check("resp_valid", bus.resp_valid, m_busy && (m_age >= W + 2));
            if (m_busy && m_age >= W + 2) check("resp_result", bus.resp_result, m_exp);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold,
                          input bit poke);
        int k;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_op1   = a;
        bus.req_op2   = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_op1   = $urandom;
        bus.req_op2   = $urandom;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.resp_valid && k < 60);
        check({name, "_latency"}, k, W + 2);
        check({name, "_result"}, bus.resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (poke) bus.req_valid = 1'b1;
            @(negedge clk);
            check({name, "_hold_valid"}, bus.resp_valid, 1'b1);
            check({name, "_hold_result"}, bus.resp_result, exp);
            check({name, "_hold_ready"}, bus.req_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check({name, "_drop"}, bus.resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_result", bus.resp_result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        check("model_mulhu", ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", ref_mul(2'b10, 32'h8000_0000, 32'h8000_0000), 32'hC000_0000);
        check("model_mul", ref_mul(2'b00, 32'hFFFF_FFFD, 32'h0000_0005), 32'hFFFF_FFF1);

        // T1
        run_op("t1_mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
        run_op("t1_mul",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        // T2
        run_op("t2_mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
        run_op("t2_mulh_m1",  2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("t2_mul_m1",   2'b00, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 0, 1'b0);
        // T3
        run_op("t3_mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("t3_mul_zero", 2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0, 1'b0);
        run_op("x_mul_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 1'b0);
        run_op("x_mulhu_2p32", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, 1'b0);
        // T4: hold in DONE with a competing request present
        run_op("t4_hold", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 10, 1'b1);

        // T5: flush at count 5 with a simultaneous new request
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_op1   = 32'd7;
        bus.req_op2   = 32'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op1   = 32'd2;
        bus.req_op2   = 32'd2;
        @(negedge clk);
        check("t5_flush_req_ready", bus.req_ready, 1'b0);
        check("t5_flush_busy", busy, 1'b1);
        @(posedge clk); #1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", busy, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("t5_no_resp", seen, 0);
        run_op("t5_next", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 0, 1'b0);

        // T6: asynchronous reset mid-CALC
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b11;
        bus.req_op1   = 32'hFFFF_FFFF;
        bus.req_op2   = 32'h0000_0002;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_resp_valid", bus.resp_valid, 1'b0);
        check("t6_rst_req_ready", bus.req_ready, 1'b1);
        check("t6_rst_resp_result", bus.resp_result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("t6_mul", 2'b00, 32'd3, 32'd5, 32'd15, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
